// File: rtl/axi_pixel_fifo_reader_pkg.sv
// Pixel type and the channel conversion used when pixels enter the output buffer.
package axi_pixel_fifo_reader_pkg;

  localparam int PIXEL_W = 24;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Flipping each channel MSB maps unsigned 0..255 onto signed -128..127.
  function automatic pixel_t zero_center(input pixel_t p, input bit enable);
    return enable ? (p ^ 24'h808080) : p;
  endfunction

endpackage

// File: rtl/pixel_skid_buffer_2.sv
// Two-entry pixel buffer: write on push, head visible combinationally, 1-cycle push-to-head.
// No internal backpressure; the upstream credit rule must never push into a full buffer.
module pixel_skid_buffer_2 #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             head_ptr;
  logic             tail_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) tail_ptr <= ~tail_ptr;
      if (pop)  head_ptr <= ~head_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_data;
  end

  assign head = mem[head_ptr];

  count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= 2'd2);
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count == 2'd2));
  no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && count == 2'd0));

endmodule

// File: rtl/axi_pixel_fifo_reader.sv
// Drains the RGB pixel FIFO into a tagged valid/ready raster stream; first pixel 2 cycles after
// the FIFO goes non-empty, then 1 pixel/cycle; o_ready low stalls with at most 2 pixels held.
module axi_pixel_fifo_reader
  import axi_pixel_fifo_reader_pkg::*;
#(
  parameter int IN_WIDTH    = 512,
  parameter int IN_HEIGHT   = 256,
  parameter int ZERO_CENTER = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [23:0]                  fifo_rd_data,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  input  logic                         en,
  output logic [23:0]                  o_data,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [$clog2(IN_HEIGHT)-1:0] o_row,
  output logic [$clog2(IN_WIDTH)-1:0]  o_col,
  output logic                         o_sof,
  output logic                         o_eol,
  output logic                         o_eof,
  output logic                         frame_done
);

  localparam int RW = $clog2(IN_HEIGHT);
  localparam int CW = $clog2(IN_WIDTH);

  logic          inflight;
  logic [1:0]    count;
  logic [2:0]    used;
  logic          hs;
  logic          last_col;
  logic          last_row;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  pixel_t        conv_data;

  assign o_valid = (count != 2'd0);
  assign hs      = o_valid && o_ready;

  // A pop this cycle frees a slot by the time the requested word lands, so it
  // counts as a credit; without it a steady stream would bubble every other cycle.
  assign used       = {1'b0, count} + {2'b00, inflight};
  assign fifo_rd_en = rst_n && en && !fifo_empty && (used < (3'd2 + {2'b00, hs}));

  assign conv_data = zero_center(fifo_rd_data, ZERO_CENTER != 0);

  pixel_skid_buffer_2 #(.WIDTH(PIXEL_W)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (conv_data),
    .pop       (hs),
    .head      (o_data),
    .count     (count)
  );

  assign last_col = (col == CW'(IN_WIDTH - 1));
  assign last_row = (row == RW'(IN_HEIGHT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight   <= 1'b0;
      row        <= '0;
      col        <= '0;
      frame_done <= 1'b0;
    end else begin
      inflight   <= fifo_rd_en;
      frame_done <= hs && last_col && last_row;
      if (hs) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign o_row = row;
  assign o_col = col;
  assign o_sof = o_valid && (row == '0) && (col == '0);
  assign o_eol = o_valid && last_col;
  assign o_eof = o_valid && last_col && last_row;

endmodule

// File: tb/tb_axi_pixel_fifo_reader.sv
module tb_axi_pixel_fifo_reader;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        o_ready;
  logic [23:0] fifo_rd_data;
  logic        fifo_empty;

  logic        rd_en_a, valid_a, sof_a, eol_a, eof_a, fd_a;
  logic [23:0] data_a;
  logic        row_a;
  logic [1:0]  col_a;
  logic        rd_en_b, valid_b, sof_b, eol_b, eof_b, fd_b;
  logic [23:0] data_b;
  logic        row_b;
  logic [1:0]  col_b;

  int checks = 0;
  int errors = 0;

  logic [23:0] mem [128];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  logic [23:0] vec [16];
  int          base;
  int          got;
  int          r0;

  axi_pixel_fifo_reader #(.IN_WIDTH(4), .IN_HEIGHT(2), .ZERO_CENTER(1)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en_a), .en(en), .o_data(data_a), .o_valid(valid_a), .o_ready(o_ready),
    .o_row(row_a), .o_col(col_a), .o_sof(sof_a), .o_eol(eol_a), .o_eof(eof_a),
    .frame_done(fd_a)
  );

  axi_pixel_fifo_reader #(.IN_WIDTH(4), .IN_HEIGHT(2), .ZERO_CENTER(0)) dut_pt (
    .clk(clk), .rst_n(rst_n), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en_b), .en(en), .o_data(data_b), .o_valid(valid_b), .o_ready(o_ready),
    .o_row(row_b), .o_col(col_b), .o_sof(sof_b), .o_eol(eol_b), .o_eof(eof_b),
    .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read FIFO model: data appears the cycle after the read strobe.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (rd_en_a) begin
      fifo_rd_data <= mem[rd_ptr % 128];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [23:0] w);
    mem[wr_ptr % 128] = w;
    wr_ptr++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    wr_ptr = rd_ptr;
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    o_ready = 1'b1;
    tick();
    tick();
    check("rst_valid_zc", {31'd0, valid_a}, 32'd0);
    check("rst_valid_pt", {31'd0, valid_b}, 32'd0);
    check("rst_rd_en", {31'd0, rd_en_a}, 32'd0);
    check("rst_row", {31'd0, row_a}, 32'd0);
    check("rst_col", {30'd0, col_a}, 32'd0);
    check("rst_frame_done", {31'd0, fd_a}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Full frame plus one pixel at o_ready=1: conversion, markers, frame_done, wrap.
    vec[0] = 24'h000000; vec[1] = 24'h80FF7F; vec[2] = 24'h010203;
    vec[3] = 24'h111213; vec[4] = 24'h212223; vec[5] = 24'h313233;
    vec[6] = 24'h414243; vec[7] = 24'h515253; vec[8] = 24'h616263;
    for (int i = 0; i < 9; i++) push_word(vec[i]);
    #1;
    check("lat_rd_en0", {31'd0, rd_en_a}, 32'd1);
    check("lat_valid0", {31'd0, valid_a}, 32'd0);
    tick();
    check("lat_valid1", {31'd0, valid_a}, 32'd0);
    check("lat_rd_en1", {31'd0, rd_en_a}, 32'd1);
    for (int k = 0; k < 9; k++) begin
      tick();
      check("f_valid", {31'd0, valid_a}, 32'd1);
      check("f_data_zc", {8'd0, data_a}, {8'd0, vec[k] ^ 24'h808080});
      check("f_data_pt", {8'd0, data_b}, {8'd0, vec[k]});
      check("f_row", {31'd0, row_a}, (k < 8) ? k / 4 : 0);
      check("f_col", {30'd0, col_a}, k % 4);
      check("f_sof", {31'd0, sof_a}, (k == 0 || k == 8) ? 1 : 0);
      check("f_eol", {31'd0, eol_a}, (k == 3 || k == 7) ? 1 : 0);
      check("f_eof", {31'd0, eof_a}, (k == 7) ? 1 : 0);
      check("f_frame_done", {31'd0, fd_a}, (k == 8) ? 1 : 0);
      check("f_rd_en", {31'd0, rd_en_a}, (k < 7) ? 1 : 0);
    end
    tick();
    check("f_end_valid", {31'd0, valid_a}, 32'd0);
    check("f_end_frame_done", {31'd0, fd_a}, 32'd0);

    // Random backpressure over 16 pixels: order, no loss, no duplication, stability.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      vec[i] = {8'(i * 17), 8'(255 - i), 8'(i * 5 + 3)};
      push_word(vec[i]);
    end
    got = 0;
    for (int c = 0; c < 300 && got < 16; c++) begin
      tick();
      check("bp_valid_match", {31'd0, valid_b}, {31'd0, valid_a});
      if (valid_a) begin
        check("bp_data_zc", {8'd0, data_a}, {8'd0, vec[got] ^ 24'h808080});
        check("bp_data_pt", {8'd0, data_b}, {8'd0, vec[got]});
        check("bp_col", {30'd0, col_a}, got % 4);
        check("bp_row", {31'd0, row_a}, (got / 4) % 2);
      end
      o_ready = 1'($urandom_range(0, 1));
      if (valid_a && o_ready) got++;
    end
    check("bp_count", got, 16);
    o_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_no_dup", {31'd0, valid_a}, 32'd0);
    end
    check("bp_end_col", {30'd0, col_a}, 32'd0);
    check("bp_end_row", {31'd0, row_a}, 32'd0);

    // o_ready=0 with a full FIFO: exactly two reads, then reads only on pop.
    do_reset();
    o_ready = 1'b0;
    r0 = rd_ptr;
    for (int i = 0; i < 6; i++) begin
      vec[i] = 24'hA00000 + 24'(i);
      push_word(vec[i]);
    end
    #1;
    check("st_rd_en0", {31'd0, rd_en_a}, 32'd1);
    tick();
    check("st_rd_en1", {31'd0, rd_en_a}, 32'd1);
    tick();
    check("st_rd_en2", {31'd0, rd_en_a}, 32'd0);
    tick();
    check("st_rd_en3", {31'd0, rd_en_a}, 32'd0);
    check("st_valid", {31'd0, valid_a}, 32'd1);
    check("st_data", {8'd0, data_b}, {8'd0, vec[0]});
    tick();
    check("st_rd_en4", {31'd0, rd_en_a}, 32'd0);
    check("st_reads", rd_ptr - r0, 2);
    check("st_hold_data", {8'd0, data_b}, {8'd0, vec[0]});
    o_ready = 1'b1;
    #1;
    check("st_pop_rd_en", {31'd0, rd_en_a}, 32'd1);
    got = 1;
    for (int c = 0; c < 20 && got < 6; c++) begin
      tick();
      if (valid_a) begin
        check("st_drain_data", {8'd0, data_b}, {8'd0, vec[got]});
        got++;
      end
    end
    check("st_drain_count", got, 6);

    // en dropped while pixel 1 is presented: pixels 0..2 still emerge, resume at col 3.
    do_reset();
    o_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vec[i] = 24'hC00000 + 24'(i * 3);
      push_word(vec[i]);
    end
    tick();
    tick();
    check("en_p0", {8'd0, data_b}, {8'd0, vec[0]});
    tick();
    check("en_p1", {8'd0, data_b}, {8'd0, vec[1]});
    en = 1'b0;
    tick();
    check("en_p2_valid", {31'd0, valid_a}, 32'd1);
    check("en_p2", {8'd0, data_b}, {8'd0, vec[2]});
    check("en_p2_col", {30'd0, col_a}, 32'd2);
    check("en_off_rd_en", {31'd0, rd_en_a}, 32'd0);
    tick();
    check("en_off_valid0", {31'd0, valid_a}, 32'd0);
    tick();
    check("en_off_valid1", {31'd0, valid_a}, 32'd0);
    check("en_off_col", {30'd0, col_a}, 32'd3);
    check("en_off_row", {31'd0, row_a}, 32'd0);
    check("en_off_eol_gated", {31'd0, eol_a}, 32'd0);
    en = 1'b1;
    #1;
    check("en_on_rd_en", {31'd0, rd_en_a}, 32'd1);
    tick();
    check("en_on_valid0", {31'd0, valid_a}, 32'd0);
    tick();
    check("en_p3", {8'd0, data_b}, {8'd0, vec[3]});
    check("en_p3_col", {30'd0, col_a}, 32'd3);
    check("en_p3_eol", {31'd0, eol_a}, 32'd1);
    check("en_p3_sof", {31'd0, sof_a}, 32'd0);
    check("en_p3_eof", {31'd0, eof_a}, 32'd0);
    tick();
    check("en_p4", {8'd0, data_b}, {8'd0, vec[4]});
    check("en_p4_row", {31'd0, row_a}, 32'd1);
    check("en_p4_col", {30'd0, col_a}, 32'd0);

    // Asynchronous reset with two pixels buffered mid-frame.
    do_reset();
    o_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(24'h0F0000 + 24'(i));
    tick();
    tick();
    tick();
    check("ar_valid_before", {31'd0, valid_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_valid_async", {31'd0, valid_a}, 32'd0);
    check("ar_rd_en_async", {31'd0, rd_en_a}, 32'd0);
    wr_ptr = rd_ptr;
    vec[0] = 24'h123456;
    vec[1] = 24'h654321;
    push_word(vec[0]);
    push_word(vec[1]);
    #1;
    check("ar_rd_en_held", {31'd0, rd_en_a}, 32'd0);
    tick();
    rst_n   = 1'b1;
    o_ready = 1'b1;
    #1;
    check("ar_rd_en_rel", {31'd0, rd_en_a}, 32'd1);
    tick();
    check("ar_valid_gap", {31'd0, valid_a}, 32'd0);
    tick();
    check("ar_valid", {31'd0, valid_a}, 32'd1);
    check("ar_data", {8'd0, data_a}, {8'd0, vec[0] ^ 24'h808080});
    check("ar_row", {31'd0, row_a}, 32'd0);
    check("ar_col", {30'd0, col_a}, 32'd0);
    check("ar_sof", {31'd0, sof_a}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
